// File: rtl/sync_fifo_thresh.sv
// Purpose: single-clock FIFO with programmable almost-full/almost-empty, sticky errors and stall interrupt.
// Latency: registered read port, data_out/rd_valid one cycle after an accepted rd_en.
// Backpressure: writes to a full FIFO are dropped (flagged) unless a read frees a slot the same cycle.
module sync_fifo_thresh #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8,
  parameter int PTR_ADDR   = $clog2(DEPTH),
  parameter int IRQ_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    data_out,
  output logic                rd_valid,
  output logic [PTR_ADDR:0]   count,
  output logic                empty,
  output logic                full,
  input  logic [PTR_ADDR:0]   af_level,
  input  logic [PTR_ADDR:0]   ae_level,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow,
  input  logic                err_clr,
  output logic                interrupt
);

  localparam int TW = $clog2(IRQ_CYCLES + 1);
  localparam logic [PTR_ADDR:0] DEPTH_C = (PTR_ADDR + 1)'(DEPTH);
  localparam logic [PTR_ADDR:0] PTR_ONE = (PTR_ADDR + 1)'(1);
  localparam logic [TW-1:0]     IRQ_C   = TW'(IRQ_CYCLES);
  localparam logic [TW-1:0]     TMR_ONE = TW'(1);

  logic [WIDTH-1:0]  mem [DEPTH];

  logic [PTR_ADDR:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_ADDR:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_ADDR:0] count_q, count_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic              rd_ok;
  logic              wr_ok;

  // Status flags come straight from the registered count and the live thresholds.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= af_level);
  assign almost_empty = (count_q <= ae_level);

  // A full FIFO still takes a write when a read frees a slot in the same cycle;
  // full implies non-empty because DEPTH >= 2, so that read is always accepted.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_en);

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign interrupt = (timer_q == IRQ_C);

  // Next-state for pointers, count, read port, error flags and stall timer.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    timer_d     = timer_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem[rd_ptr_q[PTR_ADDR-1:0]];
      rd_valid_d = 1'b1;
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase

    // Clear first so that a new error event in the same cycle takes priority.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en & full & ~rd_en) begin
      overflow_d = 1'b1;
    end
    if (rd_en & empty) begin
      underflow_d = 1'b1;
    end

    // Count consecutive stalled cycles, holding at the interrupt level.
    if (empty | full) begin
      if (timer_q != IRQ_C) begin
        timer_d = timer_q + TMR_ONE;
      end
    end else begin
      timer_d = '0;
    end
  end

  // Control and read-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      timer_q     <= timer_d;
    end
  end

  // Storage array is write-only state with no reset; stale words are never read
  // because the pointers restart together.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[wr_ptr_q[PTR_ADDR-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Purpose: directed self-checking bench for sync_fifo_thresh (DEPTH=8, WIDTH=16, IRQ_CYCLES=16).
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 time unit after the next posedge.
// Backpressure: bench tracks occupancy itself and only issues legal traffic in the wrap phase.
module tb_sync_fifo_thresh;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] data_in;
  logic        rd_en;
  logic [15:0] data_out;
  logic        rd_valid;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic [3:0]  af_level;
  logic [3:0]  ae_level;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;
  logic        err_clr;
  logic        interrupt;

  int checks = 0;
  int errors = 0;

  sync_fifo_thresh #(
    .WIDTH(16), .DEPTH(8), .IRQ_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .rd_valid(rd_valid), .count(count), .empty(empty), .full(full),
    .af_level(af_level), .ae_level(ae_level), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    logic [15:0] wr_seq;
    logic [15:0] rd_seq;
    logic do_wr;
    logic do_rd;

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0; err_clr = 1'b0;
    af_level = 4'd6; ae_level = 4'd2;
    tick();
    rst_n = 1'b1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_irq", 32'(interrupt), 32'd0);
    check("rst_rdv", 32'(rd_valid), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);

    // Idle empty: interrupt only after the 16th edge.
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("idle_irq_low", 32'(interrupt), 32'd0);
    end
    tick();
    check("idle_irq_16", 32'(interrupt), 32'd1);
    tick(); tick();
    check("idle_irq_hold", 32'(interrupt), 32'd1);

    // Fill with 1..8, checking thresholds at each count.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; data_in = 16'(i + 1);
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      check("fill_ae", 32'(almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
      if (i == 1) check("irq_drop", 32'(interrupt), 32'd0);
    end
    check("fill_full", 32'(full), 32'd1);

    // Threshold above DEPTH never reports almost_full.
    wr_en = 1'b0; af_level = 4'd9;
    #1;
    check("af_gt_depth", 32'(almost_full), 32'd0);
    af_level = 4'd6;

    // Ninth write without a read is dropped.
    wr_en = 1'b1; data_in = 16'h00FF;
    tick();
    wr_en = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Drain 1..8 with one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      check("drain_rdv", 32'(rd_valid), 32'd1);
      check("drain_data", 32'(data_out), 32'(i + 1));
    end
    rd_en = 1'b0;
    tick();
    check("drain_rdv_low", 32'(rd_valid), 32'd0);
    check("drain_hold", 32'(data_out), 32'h0008);
    check("drain_empty", 32'(empty), 32'd1);

    // Refill with 0x11..0x18 then simultaneous write/read on full.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; data_in = 16'(16'h0011 + i);
      tick();
    end
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'hBEEF;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("both_data", 32'(data_out), 32'h0011);
    check("both_rdv", 32'(rd_valid), 32'd1);
    check("both_count", 32'(count), 32'd8);
    check("both_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      check("beef_order", 32'(data_out), (i == 7) ? 32'hBEEF : 32'(16'h0012 + i));
    end
    rd_en = 1'b0;

    // Read while empty: underflow, no valid, data held.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf_set", 32'(underflow), 32'd1);
    check("udf_rdv", 32'(rd_valid), 32'd0);
    check("udf_dout", 32'(data_out), 32'hBEEF);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("udf_clr", 32'(underflow), 32'd0);

    // Set beats clear in the same cycle.
    rd_en = 1'b1; err_clr = 1'b1;
    tick();
    rd_en = 1'b0; err_clr = 1'b0;
    check("udf_set_wins", 32'(underflow), 32'd1);

    // Empty with both requests: write taken, read rejected, underflow set.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0C01;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("er_count", 32'(count), 32'd1);
    check("er_rdv", 32'(rd_valid), 32'd0);
    check("er_udf", 32'(underflow), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("er_data", 32'(data_out), 32'h0C01);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Mixed traffic well past 3*DEPTH writes to exercise pointer wrap.
    exp_cnt = 0; wr_seq = 16'h0100; rd_seq = 16'h0100;
    for (int k = 0; k < 60; k++) begin
      do_rd = ((k % 3) != 0) && (exp_cnt > 0);
      do_wr = ((k % 4) != 3) && ((exp_cnt < 8) || do_rd);
      wr_en = do_wr; rd_en = do_rd; data_in = wr_seq;
      tick();
      if (do_wr) wr_seq = wr_seq + 16'd1;
      if (do_rd) begin
        check("wrap_data", 32'(data_out), 32'(rd_seq));
        rd_seq = rd_seq + 16'd1;
      end
      if (do_wr && !do_rd) exp_cnt++;
      if (do_rd && !do_wr) exp_cnt--;
      check("wrap_count", 32'(count), 32'(exp_cnt));
    end
    wr_en = 1'b0;
    while (exp_cnt > 0) begin
      rd_en = 1'b1;
      tick();
      check("wrap_drain", 32'(data_out), 32'(rd_seq));
      rd_seq = rd_seq + 16'd1;
      exp_cnt--;
    end
    rd_en = 1'b0;
    check("wrap_overflow", 32'(overflow), 32'd0);

    // Mid-operation reset at count=5 with underflow pending.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = 16'(16'h00A0 + i);
      tick();
    end
    wr_en = 1'b0;
    check("pre_rst_count", 32'(count), 32'd5);
    check("pre_rst_udf", 32'(underflow), 32'd1);
    rst_n = 1'b0; rd_en = 1'b1;
    tick();
    rst_n = 1'b1; rd_en = 1'b0;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_ovf", 32'(overflow), 32'd0);
    check("mrst_udf", 32'(underflow), 32'd0);
    check("mrst_rdv", 32'(rd_valid), 32'd0);
    wr_en = 1'b1; data_in = 16'h0C0D;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("mrst_new_data", 32'(data_out), 32'h0C0D);
    check("mrst_new_rdv", 32'(rd_valid), 32'd1);
    tick();
    check("mrst_final_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
